// File: rtl/express_box_mealy_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : express_box_mealy_fsm
//  Purpose  : Parcel-locker controller for 16 lockers. Each deposit is given
//             a 4-digit hex password from an LFSR; a retrieval opens the
//             lowest occupied locker whose password matches the switches.
//             Drives occupancy LEDs and two multiplexed 4-digit 7-segment
//             groups, and exposes state and digit values for debug.
//  Ports    : clk            system clock
//             restart        synchronous active-low reset
//             check_bag, make_sure, get_bag, to_input   raw push buttons
//             user_password  password switches, [15:12] most significant
//             LED            LED[i]=1 when locker i+1 is occupied
//             segs0/segs1    right/left group segments {dp,g,f,e,d,c,b,a}
//             len            active-high digit enables, len[k] -> hexk
//             current_state  registered state code
//             next_state     combinational (Mealy) next state code
//             hex0..hex7     digit values being displayed (hex7 leftmost)
//  Revision : 1.0  initial release
// ============================================================================
module express_box_mealy_fsm #(
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter int          SCAN_DIV        = 50000,
    parameter logic [15:0] PW_SEED         = 16'hACE1
) (
    input  logic        clk,
    input  logic        restart,
    input  logic        check_bag,
    input  logic        make_sure,
    input  logic        get_bag,
    input  logic        to_input,
    input  logic [15:0] user_password,
    output logic [15:0] LED,
    output logic [7:0]  segs0,
    output logic [7:0]  segs1,
    output logic [7:0]  len,
    output logic [3:0]  current_state,
    output logic [3:0]  next_state,
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3,
    output logic [3:0]  hex4,
    output logic [3:0]  hex5,
    output logic [3:0]  hex6,
    output logic [3:0]  hex7
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ALLOC = 4'd1,
        S_FULL  = 4'd2,
        S_INPUT = 4'd3,
        S_OPEN  = 4'd4,
        S_ERROR = 4'd5
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: 2-FF synchronizer, debouncer, rising-edge event
    // Bit order: 0 check_bag, 1 make_sure, 2 get_bag, 3 to_input
    // ------------------------------------------------------------------
    logic [3:0] btn_raw;
    logic [3:0] btn_evt;

    assign btn_raw = {to_input, get_bag, make_sure, check_bag};

    for (genvar b = 0; b < 4; b++) begin : g_btn
        logic            sync1_q, sync2_q, level_q, evt_q;
        logic [DB_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (!restart) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                evt_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= btn_raw[b];
                sync2_q <= sync1_q;
                evt_q   <= 1'b0;
                // Counter only runs while the input disagrees with the
                // accepted level; any bounce back restarts the count.
                if (sync2_q == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q   <= '0;
                    level_q <= sync2_q;
                    evt_q   <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign btn_evt[b] = evt_q;
    end

    logic ev_check, ev_make, ev_get, ev_to;
    assign ev_check = btn_evt[0];
    assign ev_make  = btn_evt[1];
    assign ev_get   = btn_evt[2];
    assign ev_to    = btn_evt[3];

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  slot_q;
    logic [15:0] led_q;
    logic [15:0] lfsr_q;
    logic [15:0] pw_q [16];
    logic [15:0] lfsr_next;

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Lowest free slot, lowest matching occupied slot and free count.
    // Scanning downward lets the lowest index overwrite higher ones.
    logic       free_found, match_found;
    logic [3:0] free_idx, match_idx;
    logic [4:0] free_cnt;

    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        free_cnt    = '0;
        for (int i = 15; i >= 0; i--) begin
            if (!led_q[i]) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
            if (led_q[i] && (pw_q[i] == user_password)) begin
                match_found = 1'b1;
                match_idx   = 4'(i);
            end
            free_cnt = free_cnt + {4'd0, ~led_q[i]};
        end
    end

    // Mealy next-state: within each state the earlier test has priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ev_check)    state_d = free_found ? S_ALLOC : S_FULL;
                else if (ev_get) state_d = S_INPUT;
            end
            S_ALLOC: begin
                if (ev_make || ev_check) state_d = S_IDLE;
            end
            S_FULL, S_OPEN: begin
                if (ev_make) state_d = S_IDLE;
            end
            S_INPUT: begin
                if (ev_to)         state_d = match_found ? S_OPEN : S_ERROR;
                else if (ev_check) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (ev_to)        state_d = match_found ? S_OPEN : S_ERROR;
                else if (ev_make) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!restart) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            led_q   <= '0;
            lfsr_q  <= PW_SEED;
            for (int i = 0; i < 16; i++) pw_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (ev_check && free_found) slot_q <= free_idx;
                end
                S_ALLOC: begin
                    if (ev_make) begin
                        led_q[slot_q] <= 1'b1;
                        pw_q[slot_q]  <= lfsr_q;
                        lfsr_q        <= lfsr_next;
                    end
                end
                S_INPUT, S_ERROR: begin
                    if (ev_to && match_found) begin
                        led_q[match_idx] <= 1'b0;
                        pw_q[match_idx]  <= '0;
                        slot_q           <= match_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display digits
    // ------------------------------------------------------------------
    function automatic logic [7:0] to_dec(input logic [4:0] v);
        if (v >= 5'd10) to_dec = {4'd1, 4'(v - 5'd10)};
        else            to_dec = {4'd0, v[3:0]};
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 8'h3F;  4'h1: seg7 = 8'h06;  4'h2: seg7 = 8'h5B;  4'h3: seg7 = 8'h4F;
            4'h4: seg7 = 8'h66;  4'h5: seg7 = 8'h6D;  4'h6: seg7 = 8'h7D;  4'h7: seg7 = 8'h07;
            4'h8: seg7 = 8'h7F;  4'h9: seg7 = 8'h6F;  4'hA: seg7 = 8'h77;  4'hB: seg7 = 8'h7C;
            4'hC: seg7 = 8'h39;  4'hD: seg7 = 8'h5E;  4'hE: seg7 = 8'h79;  default: seg7 = 8'h71;
        endcase
    endfunction

    logic [3:0] hex [8];
    logic [4:0] slot_p1;

    assign slot_p1 = {1'b0, slot_q} + 5'd1;

    always_comb begin
        for (int i = 0; i < 8; i++) hex[i] = '0;
        case (state_q)
            S_IDLE:  {hex[1], hex[0]} = to_dec(free_cnt);
            S_ALLOC: begin
                {hex[7], hex[6], hex[5], hex[4]} = lfsr_q;
                {hex[1], hex[0]}                 = to_dec(slot_p1);
            end
            S_FULL:  for (int i = 0; i < 8; i++) hex[i] = 4'hF;
            S_INPUT: {hex[3], hex[2], hex[1], hex[0]} = user_password;
            S_OPEN:  {hex[1], hex[0]} = to_dec(slot_p1);
            S_ERROR: begin
                {hex[7], hex[6], hex[5], hex[4]} = 16'hEEEE;
                {hex[3], hex[2], hex[1], hex[0]} = user_password;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit scan: both groups share one slot index
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]        scan_k_q;

    always_ff @(posedge clk) begin
        if (!restart) begin
            scan_cnt_q <= '0;
            scan_k_q   <= '0;
        end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            scan_k_q   <= scan_k_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    assign len   = {4'b0001 << scan_k_q, 4'b0001 << scan_k_q};
    assign segs0 = seg7(hex[{1'b0, scan_k_q}]);
    assign segs1 = seg7(hex[{1'b1, scan_k_q}]);

    assign LED           = led_q;
    assign current_state = state_q;
    assign next_state    = state_d;
    assign hex0 = hex[0];
    assign hex1 = hex[1];
    assign hex2 = hex[2];
    assign hex3 = hex[3];
    assign hex4 = hex[4];
    assign hex5 = hex[5];
    assign hex6 = hex[6];
    assign hex7 = hex[7];

endmodule
`default_nettype wire

// File: tb/tb_express_box_mealy_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_express_box_mealy_fsm
//  Purpose  : Self-checking bench for the parcel-locker controller. A vector
//             table drives button presses; expected outcomes are queued at
//             drive time and popped once the press has settled. Hand-written
//             sequences cover filling all lockers, reset mid-transaction,
//             held buttons and the display scan.
//  Revision : 1.0  initial release
// ============================================================================
module tb_express_box_mealy_fsm;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk, restart;
    logic        check_bag, make_sure, get_bag, to_input;
    logic [15:0] user_password;
    logic [15:0] LED;
    logic [7:0]  segs0, segs1, len;
    logic [3:0]  current_state, next_state;
    logic [3:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    express_box_mealy_fsm #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_DIV       (8),
        .PW_SEED        (SEED)
    ) dut (
        .clk(clk), .restart(restart),
        .check_bag(check_bag), .make_sure(make_sure), .get_bag(get_bag), .to_input(to_input),
        .user_password(user_password),
        .LED(LED), .segs0(segs0), .segs1(segs1), .len(len),
        .current_state(current_state), .next_state(next_state),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] led;
        logic [15:0] hi;
        logic [7:0]  lo;
        bit          chk_hi;
        bit          chk_lo;
    } exp_t;

    typedef struct {
        int          btn;   // 0 check_bag, 1 make_sure, 2 get_bag, 3 to_input
        logic [15:0] pw;
        exp_t        e;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    vec_t vecs[8];

    int trans_cnt = 0;
    bit mon_en    = 1'b0;
    always @(negedge clk) begin
        if (mon_en && (next_state != current_state)) trans_cnt <= trans_cnt + 1;
    end

    function automatic exp_t mk(input logic [3:0] st, input logic [15:0] led,
                                input logic [15:0] hi, input logic [7:0] lo,
                                input bit ch, input bit cl);
        exp_t e;
        e.st = st; e.led = led; e.hi = hi; e.lo = lo; e.chk_hi = ch; e.chk_lo = cl;
        return e;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [7:0] dec2(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [7:0] seg_ref(input logic [3:0] d);
        logic [7:0] tbl [16];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        return tbl[d];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: check_bag = v;
            1: make_sure = v;
            2: get_bag   = v;
            3: to_input  = v;
            default: ;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        @(posedge clk); #1;
        set_btn(b, 1'b1);
        repeat (hold) @(posedge clk);
        #1;
        set_btn(b, 1'b0);
        repeat (14) @(posedge clk);
    endtask

    // Push the expectation, drive the press, then pop and compare.
    task automatic apply(input int b, input logic [15:0] pw, input exp_t e, input string tag);
        exp_t x;
        exp_q.push_back(e);
        user_password = pw;
        press(b, 12);
        @(negedge clk);
        x = exp_q.pop_front();
        chk({tag, ":state"}, 32'(current_state), 32'(x.st));
        chk({tag, ":led"},   32'(LED),           32'(x.led));
        if (x.chk_hi) chk({tag, ":hex7_4"}, 32'({hex7, hex6, hex5, hex4}), 32'(x.hi));
        if (x.chk_lo) chk({tag, ":hex1_0"}, 32'({hex1, hex0}), 32'(x.lo));
    endtask

    logic [15:0] model_lfsr;
    logic [15:0] led_model;
    logic [15:0] pw_model [16];
    logic [3:0]  exp_dig [8];

    initial begin
        restart = 1'b0; check_bag = 1'b0; make_sure = 1'b0;
        get_bag = 1'b0; to_input = 1'b0; user_password = '0;
        model_lfsr = SEED;
        led_model  = '0;

        repeat (3) @(posedge clk);
        #1 restart = 1'b1;
        @(negedge clk);
        chk("rst:state", 32'(current_state), 32'd0);
        chk("rst:led",   32'(LED),           32'h0);
        chk("rst:len",   32'(len),           32'h11);
        chk("rst:hex1_0", 32'({hex1, hex0}), 32'h16);
        chk("rst:segs0", 32'(segs0), 32'h7D);
        chk("rst:segs1", 32'(segs1), 32'h3F);

        // Deposit, bad/good retrieval, cancel
        vecs[0] = '{btn: 0, pw: 16'h0000, e: mk(4'd1, 16'h0000, 16'hACE1, 8'h01, 1, 1)};
        vecs[1] = '{btn: 1, pw: 16'h0000, e: mk(4'd0, 16'h0001, 16'h0000, 8'h15, 1, 1)};
        vecs[2] = '{btn: 2, pw: 16'h12DA, e: mk(4'd3, 16'h0001, 16'h0000, 8'hDA, 1, 1)};
        vecs[3] = '{btn: 3, pw: 16'h12DA, e: mk(4'd5, 16'h0001, 16'hEEEE, 8'hDA, 1, 1)};
        vecs[4] = '{btn: 3, pw: 16'hACE1, e: mk(4'd4, 16'h0000, 16'h0000, 8'h01, 1, 1)};
        vecs[5] = '{btn: 1, pw: 16'hACE1, e: mk(4'd0, 16'h0000, 16'h0000, 8'h16, 1, 1)};
        vecs[6] = '{btn: 2, pw: 16'h0000, e: mk(4'd3, 16'h0000, 16'h0000, 8'h00, 1, 1)};
        vecs[7] = '{btn: 0, pw: 16'h0000, e: mk(4'd0, 16'h0000, 16'h0000, 8'h16, 0, 1)};
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].btn, vecs[i].pw, vecs[i].e, $sformatf("vec%0d", i));
        end
        model_lfsr = lfsr_step(model_lfsr);

        // Fill all sixteen lockers
        for (int i = 0; i < 16; i++) begin
            apply(0, 16'h0, mk(4'd1, led_model, model_lfsr, dec2(i + 1), 1, 1), $sformatf("dep%0d_chk", i));
            pw_model[i] = model_lfsr;
            led_model   = led_model | (16'h0001 << i);
            model_lfsr  = lfsr_step(model_lfsr);
            apply(1, 16'h0, mk(4'd0, led_model, 16'h0, dec2(15 - i), 0, 1), $sformatf("dep%0d_ok", i));
        end
        chk("full:led", 32'(LED), 32'hFFFF);
        apply(0, 16'h0, mk(4'd2, 16'hFFFF, 16'hFFFF, 8'hFF, 1, 1), "full");
        chk("full:hex3_2", 32'({hex3, hex2}), 32'hFF);
        apply(1, 16'h0, mk(4'd0, 16'hFFFF, 16'h0000, 8'h00, 1, 1), "full_ack");

        // Retrieve locker 6 (index 5)
        apply(2, pw_model[5], mk(4'd3, 16'hFFFF, 16'h0, pw_model[5][7:0], 1, 1), "ret_in");
        apply(3, pw_model[5], mk(4'd4, 16'hFFDF, 16'h0, 8'h06, 1, 1), "ret_open");
        apply(1, 16'h0, mk(4'd0, 16'hFFDF, 16'h0, 8'h01, 0, 1), "ret_ack");

        // Reset while in ALLOC
        apply(0, 16'h0, mk(4'd1, 16'hFFDF, model_lfsr, 8'h06, 1, 1), "pre_rst");
        @(posedge clk); #1 restart = 1'b0;
        @(posedge clk); #1 restart = 1'b1;
        @(negedge clk);
        chk("mid_rst:state", 32'(current_state), 32'd0);
        chk("mid_rst:led",   32'(LED),           32'h0);
        chk("mid_rst:len",   32'(len),           32'h11);

        // Held button: exactly one event, password restarts at seed
        trans_cnt = 0;
        mon_en    = 1'b1;
        exp_q.push_back(mk(4'd1, 16'h0, SEED, 8'h01, 1, 1));
        press(0, 20);
        @(negedge clk);
        mon_en = 1'b0;
        begin
            exp_t x;
            x = exp_q.pop_front();
            chk("hold:state",  32'(current_state), 32'(x.st));
            chk("hold:hex7_4", 32'({hex7, hex6, hex5, hex4}), 32'(x.hi));
            chk("hold:hex1_0", 32'({hex1, hex0}), 32'(x.lo));
        end
        chk("hold:events", 32'(trans_cnt), 32'd1);

        // Scan in ALLOC: digits A,C,E,1,0,0,0,1 (hex7..hex0)
        exp_dig[0] = 4'h1; exp_dig[1] = 4'h0; exp_dig[2] = 4'h0; exp_dig[3] = 4'h0;
        exp_dig[4] = 4'h1; exp_dig[5] = 4'hE; exp_dig[6] = 4'hC; exp_dig[7] = 4'hA;
        begin
            logic [7:0] prev;
            int         c, k0, k;
            logic [3:0] oh;
            prev = len;
            c = 0;
            while (len == prev && c < 20) begin @(negedge clk); c++; end
            chk("scan:first_change", 32'(c < 20), 32'd1);
            case (len[3:0])
                4'h1: k0 = 0;
                4'h2: k0 = 1;
                4'h4: k0 = 2;
                default: k0 = 3;
            endcase
            for (int j = 0; j < 4; j++) begin
                k  = (k0 + j) % 4;
                oh = 4'(1 << k);
                chk($sformatf("scan%0d:len", j), 32'(len), 32'({oh, oh}));
                chk($sformatf("scan%0d:segs0", j), 32'(segs0), 32'(seg_ref(exp_dig[k])));
                chk($sformatf("scan%0d:segs1", j), 32'(segs1), 32'(seg_ref(exp_dig[k + 4])));
                prev = len;
                c = 0;
                while (len == prev && c < 20) begin @(negedge clk); c++; end
                chk($sformatf("scan%0d:dwell", j), 32'(c), 32'd8);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
